// File: rtl/tmr_hamming_voter_seq.sv
// rtl/tmr_hamming_voter_seq.sv - registered TMR voter over Hamming(7,4) nibble lanes with channel health tracking
// Define HAMMING_DED_EN for extended Hamming(8,4) codewords with double-error detection.
module tmr_hamming_voter_seq #(
    parameter int NIB     = 1,
    parameter int FAIL_TH = 3,
    parameter int CNT_W   = 8,
`ifdef HAMMING_DED_EN
    localparam int CW     = 8
`else
    localparam int CW     = 7
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [CW*NIB-1:0]  cw_a,
    input  logic [CW*NIB-1:0]  cw_b,
    input  logic [CW*NIB-1:0]  cw_c,
    input  logic               clr_fault,
    output logic [4*NIB-1:0]   voted_q,
    output logic               out_valid,
    output logic               corrected,
    output logic [2:0]         mismatch,
    output logic               uncorrectable,
    output logic [2:0]         ch_failed,
    output logic [3*CNT_W-1:0] err_cnt
);
    localparam logic [4:0] TH = 5'(FAIL_TH);

    typedef enum logic [1:0] {ST_ACTIVE, ST_SUSPECT, ST_FAILED} health_t;

    // Returns {double_err, corrected, d3, d2, d1, d0} for one nibble codeword.
    function automatic logic [5:0] decode(input logic [CW-1:0] cw);
        logic [6:0] c;
        logic [2:0] syn;
        logic       corr;
        logic       dbl;
        c    = cw[6:0];
        corr = 1'b0;
        dbl  = 1'b0;
        syn  = {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
`ifdef HAMMING_DED_EN
        if (syn != 3'd0 && !(^cw)) begin
            dbl = 1'b1;
        end else if (syn != 3'd0) begin
            c[syn - 3'd1] = ~c[syn - 3'd1];
            corr          = 1'b1;
        end else if (^cw) begin
            corr = 1'b1;
        end
`else
        if (syn != 3'd0) begin
            c[syn - 3'd1] = ~c[syn - 3'd1];
            corr          = 1'b1;
        end
`endif
        return {dbl, corr, c[6], c[5], c[4], c[2]};
    endfunction

    logic              r0_valid;
    logic [CW*NIB-1:0] r0_cw [3];
    logic              s1_valid;
    logic              s1_corr;
    logic [2:0]        s1_dbl;
    logic [4*NIB-1:0]  s1_data [3];
    logic [4*NIB-1:0]  dec_data [3];
    logic [2:0]        dec_dbl;
    logic              dec_corr;
    logic [5:0]        dec_r;
    health_t           state [3];
    logic [4:0]        consec [3];
    logic [CNT_W-1:0]  err [3];
    logic [2:0]        excl;
    logic [2:0]        mm;
    logic [2:0]        want;
    logic [2:0]        grant;
    logic              any_failed;
    logic [4*NIB-1:0]  vote;
    logic              unc;

    always_comb begin
        dec_corr = 1'b0;
        dec_dbl  = '0;
        dec_r    = '0;
        for (int ch = 0; ch < 3; ch++) begin
            dec_data[ch] = '0;
            for (int n = 0; n < NIB; n++) begin
                dec_r                  = decode(r0_cw[ch][n*CW +: CW]);
                dec_data[ch][n*4 +: 4] = dec_r[3:0];
                dec_corr               = dec_corr | dec_r[4];
                dec_dbl[ch]            = dec_dbl[ch] | dec_r[5];
            end
        end
    end

    // A channel sits out the vote when FAILED or, for this sample only, when it carries a double error.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            excl[i] = (state[i] == ST_FAILED) | s1_dbl[i];
        end
        vote = s1_data[0];
        unc  = 1'b0;
        case (excl)
            3'b000: vote = (s1_data[0] & s1_data[1]) | (s1_data[0] & s1_data[2]) | (s1_data[1] & s1_data[2]);
            3'b001: begin vote = s1_data[1]; unc = (s1_data[1] != s1_data[2]); end
            3'b010: begin vote = s1_data[0]; unc = (s1_data[0] != s1_data[2]); end
            3'b100: begin vote = s1_data[0]; unc = (s1_data[0] != s1_data[1]); end
            3'b011: begin vote = s1_data[2]; unc = 1'b1; end
            3'b101: begin vote = s1_data[1]; unc = 1'b1; end
            default: begin vote = s1_data[0]; unc = 1'b1; end
        endcase
        any_failed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mm[i]      = (s1_data[i] != vote) | s1_dbl[i];
            want[i]    = (state[i] == ST_SUSPECT) && mm[i] && (consec[i] + 5'd1 >= TH);
            any_failed = any_failed | (state[i] == ST_FAILED);
        end
        grant[0] = want[0] & ~any_failed;
        grant[1] = want[1] & ~want[0] & ~any_failed;
        grant[2] = want[2] & ~want[1] & ~want[0] & ~any_failed;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r0_valid      <= 1'b0;
            s1_valid      <= 1'b0;
            s1_corr       <= 1'b0;
            s1_dbl        <= '0;
            out_valid     <= 1'b0;
            voted_q       <= '0;
            corrected     <= 1'b0;
            mismatch      <= '0;
            uncorrectable <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r0_cw[i]   <= '0;
                s1_data[i] <= '0;
                state[i]   <= ST_ACTIVE;
                consec[i]  <= '0;
                err[i]     <= '0;
            end
        end else begin
            r0_valid      <= in_valid;
            r0_cw[0]      <= cw_a;
            r0_cw[1]      <= cw_b;
            r0_cw[2]      <= cw_c;
            s1_valid      <= r0_valid;
            s1_corr       <= dec_corr;
            s1_dbl        <= dec_dbl;
            out_valid     <= s1_valid;
            voted_q       <= s1_valid ? vote : '0;
            corrected     <= s1_valid & s1_corr;
            mismatch      <= s1_valid ? mm : 3'b000;
            uncorrectable <= s1_valid & unc;
            for (int i = 0; i < 3; i++) begin
                s1_data[i] <= dec_data[i];
                if (s1_valid && mm[i] && err[i] != {CNT_W{1'b1}}) begin
                    err[i] <= err[i] + 1'b1;
                end
                // clr_fault overrides the health update but never the error count.
                if (clr_fault) begin
                    state[i]  <= ST_ACTIVE;
                    consec[i] <= '0;
                end else if (s1_valid) begin
                    case (state[i])
                        ST_ACTIVE: begin
                            if (mm[i]) begin
                                state[i]  <= ST_SUSPECT;
                                consec[i] <= 5'd1;
                            end
                        end
                        ST_SUSPECT: begin
                            if (!mm[i]) begin
                                state[i]  <= ST_ACTIVE;
                                consec[i] <= '0;
                            end else if (grant[i]) begin
                                state[i]  <= ST_FAILED;
                                consec[i] <= TH;
                            end else begin
                                consec[i] <= (consec[i] + 5'd1 >= TH) ? TH : consec[i] + 5'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign ch_failed = {state[2] == ST_FAILED, state[1] == ST_FAILED, state[0] == ST_FAILED};
    assign err_cnt   = {err[2], err[1], err[0]};
endmodule
